// File: rtl/s3_pkg.sv
// Shared definitions for the S3 context retention buffer:
// FSM state encoding and context record packing layout.
package s3_pkg;

    typedef enum logic [1:0] {
        S3_IDLE   = 2'd0,
        S3_RETAIN = 2'd1,
        S3_REPLAY = 2'd2
    } s3_state_e;

    localparam int S3_DATA_W = 4;
    localparam int S3_OP_W   = 2;
    localparam int CTX_W     = 3 * S3_DATA_W + S3_OP_W;

    // Record layout, LSB first: op, b, a, result
    localparam int OFF_OP = 0;

    function automatic int ctx_w(int dw, int ow);
        return 3 * dw + ow;
    endfunction

    function automatic int off_b(int ow);
        return ow;
    endfunction

    function automatic int off_a(int dw, int ow);
        return ow + dw;
    endfunction

    function automatic int off_res(int dw, int ow);
        return ow + 2 * dw;
    endfunction

endpackage

// File: rtl/s3_ctx_mem.sv
// Context record storage: DEPTH x W registers,
// one synchronous write port, one combinational read port.
module s3_ctx_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 14
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/s3_context_store.sv
// Multi-entry S3 context retention buffer: captures ALU
// records while in S3, replays them in order on exit.
module s3_context_store
    import s3_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int OP_W      = 2,
    parameter int DEPTH     = 8,
    parameter int OVERWRITE = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       s3_state,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_result,
    input  logic [DATA_W-1:0]          in_a,
    input  logic [DATA_W-1:0]          in_b,
    input  logic [OP_W-1:0]            in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_result,
    output logic [DATA_W-1:0]          out_a,
    output logic [DATA_W-1:0]          out_b,
    output logic [OP_W-1:0]            out_op,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int XW = ctx_w(DATA_W, OP_W);
    localparam int OB = off_b(OP_W);
    localparam int OA = off_a(DATA_W, OP_W);
    localparam int OR = off_res(DATA_W, OP_W);

    s3_state_e     state_q, state_d;
    logic [PW-1:0] wr_ptr, wr_d;
    logic [PW-1:0] rd_ptr, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          clr;

    logic          full;
    logic          push;
    logic          pop;
    logic [XW-1:0] rdata;

    assign full      = (cnt_q == CW'(DEPTH));
    assign in_ready  = (state_q == S3_RETAIN) &&
                       (!full || OVERWRITE != 0);
    assign push      = in_valid && in_ready;
    assign out_valid = (state_q == S3_REPLAY) && (cnt_q != '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_ptr;
        rd_d    = rd_ptr;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        clr     = 1'b0;
        unique case (state_q)
            S3_IDLE: begin
                if (s3_state) begin
                    state_d = S3_RETAIN;
                    clr     = 1'b1;
                end
            end
            S3_RETAIN: begin
                if (push) begin
                    wr_d = wr_ptr + 1'b1;
                    // Full overwrite: drop oldest, count unchanged
                    if (full) begin
                        rd_d  = rd_ptr + 1'b1;
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (in_valid && full) begin
                    ovf_d = 1'b1;
                end
                if (!s3_state) begin
                    state_d = (cnt_d != '0) ? S3_REPLAY : S3_IDLE;
                end
            end
            S3_REPLAY: begin
                if (s3_state) begin
                    state_d = S3_RETAIN;
                    clr     = 1'b1;
                end else begin
                    if (pop) begin
                        rd_d  = rd_ptr + 1'b1;
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (cnt_d == '0) begin
                        state_d = S3_IDLE;
                    end
                end
            end
            default: begin
                state_d = S3_IDLE;
            end
        endcase
        if (clr) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S3_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_ptr  <= wr_d;
            rd_ptr  <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    s3_ctx_mem #(
        .DEPTH (DEPTH),
        .W     (XW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({in_result, in_a, in_b, in_op}),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign out_result = out_valid ? rdata[OR +: DATA_W] : '0;
    assign out_a      = out_valid ? rdata[OA +: DATA_W] : '0;
    assign out_b      = out_valid ? rdata[OB +: DATA_W] : '0;
    assign out_op     = out_valid ? rdata[OFF_OP +: OP_W] : '0;
    assign count      = cnt_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != S3_IDLE);

endmodule

// File: tb/tb_s3_context_store.sv
// Bench: two buffers (reject / overwrite policy) driven in
// lockstep and compared against a queue-based reference.
module tb_s3_context_store;

    localparam int DW    = 4;
    localparam int OW    = 2;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    localparam int M_IDLE = 0;
    localparam int M_RET  = 1;
    localparam int M_REP  = 2;

    typedef struct packed {
        logic [DW-1:0] r;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [OW-1:0] op;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s3 = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_result = '0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [OW-1:0] in_op = '0;

    logic          ir  [2];
    logic          ov  [2];
    logic          ovf [2];
    logic          bz  [2];
    logic [DW-1:0] orr [2];
    logic [DW-1:0] oa  [2];
    logic [DW-1:0] ob  [2];
    logic [OW-1:0] oop [2];
    logic [CW-1:0] cnt [2];

    s3_context_store #(
        .DATA_W(DW), .OP_W(OW), .DEPTH(DEPTH), .OVERWRITE(0)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .s3_state(s3),
        .in_valid(in_valid), .in_ready(ir[0]),
        .in_result(in_result), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .out_valid(ov[0]), .out_ready(out_ready),
        .out_result(orr[0]), .out_a(oa[0]), .out_b(ob[0]),
        .out_op(oop[0]), .count(cnt[0]), .overflow(ovf[0]),
        .busy(bz[0])
    );

    s3_context_store #(
        .DATA_W(DW), .OP_W(OW), .DEPTH(DEPTH), .OVERWRITE(1)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .s3_state(s3),
        .in_valid(in_valid), .in_ready(ir[1]),
        .in_result(in_result), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .out_valid(ov[1]), .out_ready(out_ready),
        .out_result(orr[1]), .out_a(oa[1]), .out_b(ob[1]),
        .out_op(oop[1]), .count(cnt[1]), .overflow(ovf[1]),
        .busy(bz[1])
    );

    always #5 clk = ~clk;

    rec_t q0[$];
    rec_t q1[$];
    int   mode [2];
    bit   movf [2];
    int   checks = 0;
    int   errors = 0;

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic rec_t qfront(int d);
        if (d == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic qpush(int d, rec_t r);
        if (d == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    task automatic qpop(int d);
        rec_t t;
        if (d == 0) t = q0.pop_front();
        else t = q1.pop_front();
    endtask

    task automatic qclr(int d);
        if (d == 0) q0.delete();
        else q1.delete();
    endtask

    task automatic chk(string tag, int d,
                       logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h",
                   tag, d, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int   n;
            bit   v;
            rec_t f;
            n = qsize(d);
            v = (mode[d] == M_REP) && (n > 0);
            f = v ? qfront(d) : '0;
            chk("in_ready", d, ir[d],
                (mode[d] == M_RET) && (n < DEPTH || d == 1));
            chk("out_valid", d, ov[d], v);
            chk("out_result", d, orr[d], f.r);
            chk("out_a", d, oa[d], f.a);
            chk("out_b", d, ob[d], f.b);
            chk("out_op", d, oop[d], f.op);
            chk("count", d, cnt[d], n);
            chk("overflow", d, ovf[d], movf[d]);
            chk("busy", d, bz[d], mode[d] != M_IDLE);
        end
    endtask

    task automatic model_edge();
        rec_t r;
        r = '{r: in_result, a: in_a, b: in_b, op: in_op};
        for (int d = 0; d < 2; d++) begin
            if (mode[d] == M_IDLE) begin
                if (s3) begin
                    mode[d] = M_RET;
                    qclr(d);
                    movf[d] = 1'b0;
                end
            end else if (mode[d] == M_RET) begin
                if (in_valid) begin
                    if (qsize(d) < DEPTH) begin
                        qpush(d, r);
                    end else if (d == 1) begin
                        qpop(d);
                        qpush(d, r);
                        movf[d] = 1'b1;
                    end else begin
                        movf[d] = 1'b1;
                    end
                end
                if (!s3) mode[d] = (qsize(d) > 0) ? M_REP : M_IDLE;
            end else begin
                if (s3) begin
                    mode[d] = M_RET;
                    qclr(d);
                    movf[d] = 1'b0;
                end else begin
                    if (qsize(d) > 0 && out_ready) qpop(d);
                    if (qsize(d) == 0) mode[d] = M_IDLE;
                end
            end
        end
    endtask

    task automatic step();
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit s, bit v, bit rdy,
                         int r, int a, int b, int op);
        s3        = s;
        in_valid  = v;
        out_ready = rdy;
        in_result = DW'(r);
        in_a      = DW'(a);
        in_b      = DW'(b);
        in_op     = OW'(op);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mode[d] = M_IDLE;
            movf[d] = 1'b0;
            qclr(d);
        end
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
    endtask

    task automatic rnd_save(bit s, int r);
        drive(s, 1'b1, 1'b0, r, $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 3));
    endtask

    initial begin
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        mode = '{M_IDLE, M_IDLE};
        movf = '{1'b0, 1'b0};

        do_reset();

        // Three saves, the last coinciding with s3 falling
        drive(1, 0, 0, 0, 0, 0, 0); step();
        drive(1, 1, 0, 3, 1, 2, 0); step();
        drive(1, 1, 0, 7, 5, 2, 0); step();
        drive(0, 1, 0, 2, 6, 4, 1); step();
        drive(0, 0, 1, 0, 0, 0, 0);
        repeat (5) step();

        // Ten saves: reject vs overwrite policies
        drive(1, 0, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 10; i++) begin
            rnd_save(1, i);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 24; k++) begin
            out_ready = pat[k % 4];
            step();
        end

        // Re-enter S3 after one of four entries replayed
        drive(1, 0, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 4; i++) begin
            rnd_save(1, 10 + i);
            step();
        end
        drive(0, 0, 1, 0, 0, 0, 0); step();
        step();
        drive(1, 0, 1, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0, 0, 0);
        repeat (4) step();

        // Reset in the middle of RETAIN with five entries
        drive(1, 0, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 5; i++) begin
            rnd_save(1, i + 3);
            step();
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        do_reset();
        step();
        drive(0, 0, 1, 0, 0, 0, 0);
        repeat (3) step();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) s3 = ~s3;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            in_result = DW'($urandom);
            in_a      = DW'($urandom);
            in_b      = DW'($urandom);
            in_op     = OW'($urandom);
            step();
        end
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/s3_context_store.md
# s3_context_store

Parametrised multi-entry S3 context retention buffer. It sits between the ALU and the power controller. While `s3_state` is high it captures up to `DEPTH` ALU context records (result, operand A, operand B, opcode) through a valid/ready handshake. When `s3_state` falls, it replays the stored records in arrival order through a second valid/ready handshake. It supersedes the single-entry store: depth is parametrised, and a selectable overflow policy is provided.

## Interface
Parameters:
- `DATA_W`, 4: width of result and each operand.
- `OP_W`, 2: opcode width.
- `DEPTH`, 8: number of context entries; power of two, ≥2.
- `OVERWRITE`, 0: full-buffer policy. 0 rejects new saves; 1 overwrites the oldest entry.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s3_state`  in  1  S3 power-state request, sampled every cycle.
- `in_valid`  in  1  save request.
- `in_ready`  out  1  save accepted when `in_valid && in_ready`.
- `in_result`, `in_a`, `in_b`  in  DATA_W  context to save.
- `in_op`  in  OP_W  opcode to save.
- `out_valid`  out  1  replay entry available.
- `out_ready`  in  1  consumer accepts replay entry.
- `out_result`, `out_a`, `out_b`  out  DATA_W  replayed context.
- `out_op`  out  OP_W  replayed opcode.
- `count`  out  $clog2(DEPTH+1)  entries held.
- `overflow`  out  1  sticky flag: a save was lost or overwritten in the current S3 episode.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: `in_ready`=0, `out_valid`=0. `s3_state`=1 → RETAIN.
  - RETAIN: saves are accepted. `s3_state`=0 → REPLAY if `count`>0, else IDLE.
  - REPLAY: entries are drained. `count` reaching 0 → IDLE. `s3_state`=1 → RETAIN, discarding undrained entries.
- Entering RETAIN clears the write and read pointers, `count` and `overflow`.
- RETAIN, `in_ready` = (`count` < DEPTH) || OVERWRITE.
  - On a handshake, the record is written at `wr_ptr`, `wr_ptr` increments modulo DEPTH and `count` increments.
  - Full with OVERWRITE=1: the write replaces the oldest entry, `rd_ptr` advances, `count` stays DEPTH and `overflow` sets.
  - Full with OVERWRITE=0: `in_ready`=0. `in_valid`=1 sets `overflow`; nothing is written.
- REPLAY:
  - `out_valid` = (`count` > 0).
  - `out_*` = entry at `rd_ptr`.
  - A handshake increments `rd_ptr` modulo DEPTH and decrements `count`.
  - `in_ready`=0 and `in_valid` is ignored.
- `out_*` data fields are forced to 0 whenever `out_valid`=0.
- `in_ready` depends only on the registered state and `count`. A save handshake in the same cycle that `s3_state` drops is therefore stored and included in the replay.
- Pointer wrap-around uses natural modulo-DEPTH rollover; `count` carries the full/empty distinction.

## Timing
- Reset (asynchronous assert, synchronous deassert at the system level): state IDLE, pointers 0, `count`=0, `overflow`=0, `busy`=0, `in_ready`=0, `out_valid`=0, all `out_*`=0. Array contents are not reset.
- `reset_n` asserted mid-RETAIN or mid-REPLAY discards all contents; the block returns to IDLE.
- State transitions take effect one cycle after `s3_state` is sampled:
  - `s3_state`=1 at edge k gives `in_ready`=1 in cycle k+1.
  - `s3_state`=0 at edge k gives `out_valid`=1 in cycle k+1.
- `count` and `overflow` update on the edge of the handshake.
- Throughput is one save or one replay per cycle. Replay holds `out_*` stable while `out_valid && !out_ready`.
- The last replay handshake at edge k gives IDLE and `busy`=0 in cycle k+1.

## Structure
- Shared package `s3_pkg` holds:
  - State encoding constants S3_IDLE, S3_RETAIN, S3_REPLAY.
  - CTX_W = 3*DATA_W + OP_W.
  - Field offsets for packing and unpacking a context record.
- Sub-module `s3_ctx_mem`: DEPTH × CTX_W register array with one synchronous write port and one combinational read port; no reset on the array.
- The top level holds the FSM, pointers, `count`, `overflow` and output masking.

## Test plan
- Reset, then `s3_state`=1 with saves (r,a,b,op) = (3,1,2,0), (7,5,2,0), (2,6,4,1), then `s3_state`=0. Replay returns the same three records in order; `count` 3→0; `busy` drops the cycle after the last pop.
- DEPTH=8, OVERWRITE=0, 10 saves of result 0..9. `in_ready`=0 after 8; `overflow`=1; replay yields 0..7.
- DEPTH=8, OVERWRITE=1, 10 saves of result 0..9. `in_ready` stays 1; `overflow`=1; replay yields 2..9.
- Replay with `out_ready` toggled 1,0,0,1. `out_*` is held stable during stalls; no entry is duplicated or skipped.
- `s3_state` reasserted after 1 of 4 entries is replayed. The block returns to RETAIN with `count`=0 and `overflow`=0; the 3 remaining entries are never output.
- `reset_n` pulsed low mid-RETAIN with 5 entries. All outputs return to 0 asynchronously; a following `s3_state` 1→0 with no saves returns to IDLE with no `out_valid`.
